// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the memory-stage state encoding, plus the select and
// direction constants that the multicycle control FSM also uses.
package cpu_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2,
    MEM_ERR  = 2'd3
  } mem_state_t;

  localparam logic MEM_SEL_PC   = 1'b0;
  localparam logic MEM_SEL_DATA = 1'b1;
  localparam logic MEM_READ     = 1'b1;
  localparam logic MEM_WRITE    = 1'b0;

  // Writes are only meaningful for data stores; a write aimed at the fetch
  // address or at the IR has no legal use in this datapath.
  function automatic logic mem_req_illegal(input logic mem_select,
                                           input logic mem_read_not_write,
                                           input logic ir_write);
    return (mem_read_not_write == MEM_WRITE) &&
           ((mem_select == MEM_SEL_PC) || ir_write);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting on the memory bus; expired marks the waiting
// cycle that brings the count to TIMEOUT_CYCLES.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int COUNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(TIMEOUT_CYCLES - 1);

  logic [COUNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + COUNT_W'(1);
    end
  end

  assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle CPU: turns control's access intent into
// one req/ack bus transaction and holds the IR and MDR it loads.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic                  mem_select,
  input  logic                  mem_read_not_write,
  input  logic                  ir_write,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] mdr,
  output logic                  acc_done,
  output logic                  acc_error
);

  mem_state_t state, state_next;

  logic                  accept;
  logic                  illegal;
  logic                  in_req;
  logic                  timeout_hit;
  logic                  read_acked;

  logic                  req_we;
  logic                  req_ir_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic                  error_q;

  assign accept     = acc_valid && (state == MEM_IDLE);
  assign illegal    = mem_req_illegal(mem_select, mem_read_not_write, ir_write);
  assign in_req     = (state == MEM_REQ);
  assign read_acked = in_req && bus_ack && !req_we;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (in_req),
    .expired (timeout_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An ack arriving on the same edge as the timeout still completes the access.
  always_comb begin
    state_next = state;
    acc_ready  = 1'b0;
    bus_req    = 1'b0;
    acc_done   = 1'b0;
    case (state)
      MEM_IDLE: begin
        acc_ready = 1'b1;
        if (acc_valid) begin
          state_next = illegal ? MEM_ERR : MEM_REQ;
        end
      end
      MEM_REQ: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          state_next = MEM_DONE;
        end else if (timeout_hit) begin
          state_next = MEM_ERR;
        end
      end
      MEM_DONE: begin
        acc_done   = 1'b1;
        state_next = MEM_IDLE;
      end
      MEM_ERR: begin
        acc_done   = 1'b1;
        state_next = MEM_IDLE;
      end
      default: begin
        state_next = MEM_IDLE;
      end
    endcase
  end

  // The request is captured once at accept so the bus stays stable even if
  // control moves on to its next micro-step while we wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_we       <= 1'b0;
      req_ir_write <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
    end else if (accept) begin
      req_we       <= (mem_read_not_write == MEM_WRITE);
      req_ir_write <= ir_write;
      req_addr     <= (mem_select == MEM_SEL_PC) ? pc : data_addr;
      req_wdata    <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q  <= '0;
      mdr_q <= '0;
    end else if (read_acked) begin
      if (req_ir_write) begin
        ir_q <= bus_rdata;
      end else begin
        mdr_q <= bus_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= illegal;
    end else if (in_req && !bus_ack && timeout_hit) begin
      error_q <= 1'b1;
    end
  end

  assign bus_we    = in_req && req_we;
  assign bus_addr  = req_addr;
  assign bus_wdata = req_wdata;
  assign instr     = ir_q;
  assign mdr       = mdr_q;
  assign acc_error = error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, corner-case
// sequences, then random accesses against a transaction-level model.
module tb_mem_access_unit;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          acc_valid;
  logic          acc_ready;
  logic          mem_select;
  logic          mem_read_not_write;
  logic          ir_write;
  logic [AW-1:0] pc;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] wdata;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic [DW-1:0] instr;
  logic [DW-1:0] mdr;
  logic          acc_done;
  logic          acc_error;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .acc_valid          (acc_valid),
    .acc_ready          (acc_ready),
    .mem_select         (mem_select),
    .mem_read_not_write (mem_read_not_write),
    .ir_write           (ir_write),
    .pc                 (pc),
    .data_addr          (data_addr),
    .wdata              (wdata),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_ack            (bus_ack),
    .bus_rdata          (bus_rdata),
    .instr              (instr),
    .mdr                (mdr),
    .acc_done           (acc_done),
    .acc_error          (acc_error)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic          sel;
    logic          rnw;
    logic          irw;
    logic [AW-1:0] pc_v;
    logic [AW-1:0] addr_v;
    logic [DW-1:0] wdata_v;
    int            ack_delay;
    logic [DW-1:0] rdata_v;
    logic          exp_error;
    int            exp_req_cycles;
    logic [DW-1:0] exp_instr;
    logic [DW-1:0] exp_mdr;
  } vec_t;

  vec_t vecs[9];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from IDLE and plays the memory side: ack is given in the
  // REQ cycle whose zero-based index equals ack_delay (never, if it is >= TO).
  task automatic apply_stimulus(input logic sel, input logic rnw, input logic irw,
                                input logic [AW-1:0] pc_v, input logic [AW-1:0] addr_v,
                                input logic [DW-1:0] wdata_v, input int ack_delay,
                                input logic [DW-1:0] rdata_v,
                                output logic done_seen, output int req_seen);
    logic [AW-1:0] exp_addr;
    int            cycles;
    exp_addr = sel ? addr_v : pc_v;
    req_seen = 0;
    cycles   = 0;
    check_output("ready_before_accept", acc_ready, 1);
    acc_valid          = 1'b1;
    mem_select         = sel;
    mem_read_not_write = rnw;
    ir_write           = irw;
    pc                 = pc_v;
    data_addr          = addr_v;
    wdata              = wdata_v;
    bus_ack            = 1'b0;
    step();
    acc_valid          = 1'($urandom);
    mem_select         = 1'($urandom);
    mem_read_not_write = 1'($urandom);
    ir_write           = 1'($urandom);
    pc                 = AW'($urandom);
    data_addr          = AW'($urandom);
    wdata              = DW'($urandom);
    while (!acc_done && cycles < 40) begin
      cycles++;
      check_output("busy_ready_low", acc_ready, 0);
      if (bus_req) begin
        check_output("bus_we_addr", {bus_we, bus_addr}, {!rnw, exp_addr});
        if (!rnw) check_output("bus_wdata", bus_wdata, wdata_v);
        bus_ack   = (req_seen == ack_delay);
        bus_rdata = bus_ack ? rdata_v : DW'($urandom);
        req_seen++;
      end else begin
        bus_ack = 1'b0;
      end
      step();
    end
    done_seen = acc_done;
    bus_ack   = 1'b0;
    acc_valid = 1'b0;
    step();
    check_output("after_done_idle", {acc_done, acc_ready, bus_req}, 3'b010);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic          done_seen;
    int            req_seen;
    logic          r_sel, r_rnw, r_irw, m_illegal, m_timeout;
    logic [AW-1:0] r_pc, r_addr;
    logic [DW-1:0] r_wdata, r_rdata, model_ir, model_mdr;
    int            r_delay, m_req;

    //            sel   rnw   irw   pc     addr   wdata     dly rdata     err  req ir        mdr
    vecs[0] = '{1'b0, 1'b1, 1'b1, 8'h10, 8'h77, 16'h0000, 0,  16'hA5C3, 1'b0, 1, 16'hA5C3, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h55, 8'h22, 16'h0000, 3,  16'h1234, 1'b0, 4, 16'hA5C3, 16'h1234};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h40, 16'hBEEF, 2,  16'hFFFF, 1'b0, 3, 16'hA5C3, 16'h1234};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h02, 8'h33, 16'h0000, 99, 16'hDEAD, 1'b1, 15, 16'hA5C3, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h03, 8'h08, 16'h0000, 1,  16'h0F0F, 1'b0, 2, 16'h0F0F, 16'h1234};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h20, 8'h21, 16'h5555, 0,  16'h1111, 1'b1, 0, 16'h0F0F, 16'h1234};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h30, 8'h31, 16'h6666, 0,  16'h2222, 1'b1, 0, 16'h0F0F, 16'h1234};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h04, 8'hFF, 16'h1357, 14, 16'h3333, 1'b0, 15, 16'h0F0F, 16'h1234};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 8'h05, 8'h0C, 16'h0000, 14, 16'h2468, 1'b0, 15, 16'h0F0F, 16'h2468};

    reset              = 1'b0;
    acc_valid          = 1'b0;
    mem_select         = 1'b0;
    mem_read_not_write = 1'b1;
    ir_write           = 1'b0;
    pc                 = '0;
    data_addr          = '0;
    wdata              = '0;
    bus_ack            = 1'b0;
    bus_rdata          = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_ctrl", {acc_ready, bus_req, bus_we, acc_done, acc_error}, 5'b10000);
    check_output("reset_bus", {bus_addr, bus_wdata}, 0);
    check_output("reset_regs", {instr, mdr}, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].sel, vecs[i].rnw, vecs[i].irw, vecs[i].pc_v, vecs[i].addr_v,
                     vecs[i].wdata_v, vecs[i].ack_delay, vecs[i].rdata_v, done_seen, req_seen);
      check_output($sformatf("vec%0d_done", i), done_seen, 1);
      check_output($sformatf("vec%0d_req_cycles", i), req_seen, vecs[i].exp_req_cycles);
      check_output($sformatf("vec%0d_error", i), acc_error, vecs[i].exp_error);
      check_output($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
      check_output($sformatf("vec%0d_mdr", i), mdr, vecs[i].exp_mdr);
    end

    // Spurious ack while idle must not move the FSM or touch IR/MDR.
    bus_ack   = 1'b1;
    bus_rdata = 16'hFACE;
    repeat (3) begin
      step();
      check_output("spurious_ctrl", {acc_ready, bus_req, acc_done}, 3'b100);
    end
    bus_ack = 1'b0;
    step();
    check_output("spurious_instr", instr, 16'h0F0F);
    check_output("spurious_mdr", mdr, 16'h2468);

    // Reset asserted between clock edges while a read is waiting on the bus.
    acc_valid          = 1'b1;
    mem_select         = 1'b1;
    mem_read_not_write = 1'b1;
    ir_write           = 1'b0;
    data_addr          = 8'h5A;
    step();
    acc_valid = 1'b0;
    step();
    check_output("pre_reset_req", bus_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset_ctrl", {bus_req, acc_ready, acc_done}, 3'b010);
    check_output("async_reset_regs", {instr, mdr}, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_output("post_reset_ready", acc_ready, 1);

    model_ir  = '0;
    model_mdr = '0;
    for (int n = 0; n < 40; n++) begin
      r_sel   = 1'($urandom);
      r_rnw   = ($urandom_range(0, 3) != 0);
      r_irw   = 1'($urandom);
      r_pc    = AW'($urandom);
      r_addr  = AW'($urandom);
      r_wdata = DW'($urandom);
      r_rdata = DW'($urandom);
      r_delay = $urandom_range(0, 17);
      m_illegal = !r_rnw && (!r_sel || r_irw);
      m_timeout = !m_illegal && (r_delay >= TO);
      m_req     = m_illegal ? 0 : (m_timeout ? TO : r_delay + 1);
      if (!m_illegal && !m_timeout && r_rnw) begin
        if (r_irw) model_ir = r_rdata;
        else       model_mdr = r_rdata;
      end
      apply_stimulus(r_sel, r_rnw, r_irw, r_pc, r_addr, r_wdata, r_delay, r_rdata,
                     done_seen, req_seen);
      check_output($sformatf("rnd%0d_done", n), done_seen, 1);
      check_output($sformatf("rnd%0d_req_cycles", n), req_seen, m_req);
      check_output($sformatf("rnd%0d_error", n), acc_error, m_illegal || m_timeout);
      check_output($sformatf("rnd%0d_instr", n), instr, model_ir);
      check_output($sformatf("rnd%0d_mdr", n), mdr, model_mdr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
